// File: rtl/param_updown_counter.sv
// param_updown_counter
// Parameterised up/down counter with a selectable step, saturate or wrap
// behaviour at the range limits, a synchronous load, one-cycle overflow and
// underflow pulses, and sticky copies of those pulses.
// Range arithmetic is done one bit wider than the count so that
// count+step and count+modulus never lose their carry.

module param_updown_counter #(
  parameter int     WIDTH     = 6,
  parameter longint MAX_VAL   = (64'd1 << WIDTH) - 1,
  parameter longint RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] count,
  output logic             ovf_p,
  output logic             udf_p,
  output logic             ovf_sticky,
  output logic             udf_sticky,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
  // Modulus MAX_VAL+1; may equal 2**WIDTH, hence the extra bit
  localparam logic [WIDTH:0]   MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_p_q, ovf_p_d;
  logic             udf_p_q, udf_p_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic             udf_sticky_q, udf_sticky_d;

  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] load_eff;
  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   step_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   wrap_up_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH:0]   wrap_dn_ext;

  // Next-state computation: load beats enable, clamping of step and load
  // value, and boundary handling in both directions
  always_comb begin
    step_eff    = (step > MAX_W) ? MAX_W : step;
    load_eff    = (load_val > MAX_W) ? MAX_W : load_val;
    cnt_ext     = {1'b0, count_q};
    step_ext    = {1'b0, step_eff};
    sum_ext     = cnt_ext + step_ext;
    wrap_up_ext = sum_ext - MOD_EXT;
    diff_ext    = cnt_ext - step_ext;
    wrap_dn_ext = cnt_ext + (MOD_EXT - step_ext);

    count_d = count_q;
    ovf_p_d = 1'b0;
    udf_p_d = 1'b0;

    if (load) begin
      count_d = load_eff;
    end else if (en) begin
      if (up_down) begin
        if (sum_ext > MAX_EXT) begin
          ovf_p_d = 1'b1;
          count_d = sat ? MAX_W : WIDTH'(wrap_up_ext);
        end else begin
          count_d = WIDTH'(sum_ext);
        end
      end else begin
        if (step_ext > cnt_ext) begin
          udf_p_d = 1'b1;
          count_d = sat ? '0 : WIDTH'(wrap_dn_ext);
        end else begin
          count_d = WIDTH'(diff_ext);
        end
      end
    end

    // A new event on this edge wins over a clear request
    ovf_sticky_d = ovf_p_d | (ovf_sticky_q & ~flag_clr);
    udf_sticky_d = udf_p_d | (udf_sticky_q & ~flag_clr);
  end

  // State registers with synchronous reset overriding everything else
  always_ff @(posedge Clk) begin
    if (reset) begin
      count_q      <= RESET_W;
      ovf_p_q      <= 1'b0;
      udf_p_q      <= 1'b0;
      ovf_sticky_q <= 1'b0;
      udf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_p_q      <= ovf_p_d;
      udf_p_q      <= udf_p_d;
      ovf_sticky_q <= ovf_sticky_d;
      udf_sticky_q <= udf_sticky_d;
    end
  end

  assign count      = count_q;
  assign ovf_p      = ovf_p_q;
  assign udf_p      = udf_p_q;
  assign ovf_sticky = ovf_sticky_q;
  assign udf_sticky = udf_sticky_q;
  assign at_max     = (count_q == MAX_W);
  assign at_zero    = (count_q == '0);

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter
// Directed test of two counter instances: the default 6-bit/63 build (A)
// and a 4-bit build with MAX_VAL=9, RESET_VAL=2 (B).

module tb_param_updown_counter;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       a_reset, a_en, a_up_down, a_sat, a_load, a_flag_clr;
  logic [5:0] a_step, a_load_val, a_count;
  logic       a_ovf_p, a_udf_p, a_ovf_sticky, a_udf_sticky, a_at_max, a_at_zero;

  logic       b_reset, b_en, b_up_down, b_sat, b_load, b_flag_clr;
  logic [3:0] b_step, b_load_val, b_count;
  logic       b_ovf_p, b_udf_p, b_ovf_sticky, b_udf_sticky, b_at_max, b_at_zero;

  int checks = 0;
  int errors = 0;

  param_updown_counter dut_a (
    .Clk(Clk), .reset(a_reset), .en(a_en), .up_down(a_up_down), .sat(a_sat),
    .step(a_step), .load(a_load), .load_val(a_load_val), .flag_clr(a_flag_clr),
    .count(a_count), .ovf_p(a_ovf_p), .udf_p(a_udf_p), .ovf_sticky(a_ovf_sticky),
    .udf_sticky(a_udf_sticky), .at_max(a_at_max), .at_zero(a_at_zero)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(2)) dut_b (
    .Clk(Clk), .reset(b_reset), .en(b_en), .up_down(b_up_down), .sat(b_sat),
    .step(b_step), .load(b_load), .load_val(b_load_val), .flag_clr(b_flag_clr),
    .count(b_count), .ovf_p(b_ovf_p), .udf_p(b_udf_p), .ovf_sticky(b_ovf_sticky),
    .udf_sticky(b_udf_sticky), .at_max(b_at_max), .at_zero(b_at_zero)
  );

  // Single comparison point; every check is counted here
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one edge on the selected instance (0=A, 1=B); the other idles
  task automatic applyStimulus(input bit sel, input bit rst, input bit ld, input logic [5:0] ldv,
                               input bit e, input bit ud, input bit sa, input logic [5:0] st,
                               input bit fc);
    a_reset = 0; a_load = 0; a_en = 0; a_flag_clr = 0;
    b_reset = 0; b_load = 0; b_en = 0; b_flag_clr = 0;
    if (!sel) begin
      a_reset = rst; a_load = ld; a_load_val = ldv; a_en = e;
      a_up_down = ud; a_sat = sa; a_step = st; a_flag_clr = fc;
    end else begin
      b_reset = rst; b_load = ld; b_load_val = ldv[3:0]; b_en = e;
      b_up_down = ud; b_sat = sa; b_step = st[3:0]; b_flag_clr = fc;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic checkA(input string tag, input int cnt, input bit ovf, input bit udf);
    checkOutput({tag, " A count"}, 32'(a_count), 32'(cnt));
    checkOutput({tag, " A ovf_p"}, 32'(a_ovf_p), 32'(ovf));
    checkOutput({tag, " A udf_p"}, 32'(a_udf_p), 32'(udf));
  endtask

  task automatic checkB(input string tag, input int cnt, input bit ovf, input bit udf);
    checkOutput({tag, " B count"}, 32'(b_count), 32'(cnt));
    checkOutput({tag, " B ovf_p"}, 32'(b_ovf_p), 32'(ovf));
    checkOutput({tag, " B udf_p"}, 32'(b_udf_p), 32'(udf));
  endtask

  initial begin
    a_reset = 0; a_en = 0; a_up_down = 0; a_sat = 0; a_load = 0; a_flag_clr = 0;
    a_step = 0; a_load_val = 0;
    b_reset = 0; b_en = 0; b_up_down = 0; b_sat = 0; b_load = 0; b_flag_clr = 0;
    b_step = 0; b_load_val = 0;
    #2;

    // Reset both instances on the same edge, with load/en/flag_clr active
    a_reset = 1; a_load = 1; a_load_val = 6'd20; a_en = 1; a_up_down = 1; a_step = 6'd1; a_flag_clr = 1;
    b_reset = 1; b_load = 1; b_load_val = 4'd5;  b_en = 1; b_up_down = 1; b_step = 4'd1;
    @(posedge Clk); #1;
    checkA("reset", 0, 0, 0);
    checkOutput("reset A ovf_sticky", 32'(a_ovf_sticky), 0);
    checkOutput("reset A udf_sticky", 32'(a_udf_sticky), 0);
    checkOutput("reset A at_zero", 32'(a_at_zero), 1);
    checkOutput("reset A at_max", 32'(a_at_max), 0);
    checkB("reset+load", 2, 0, 0);

    // Full wrap sweep on the default build
    for (int i = 1; i <= 64; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 6'd1, 0);
      checkOutput("sweep A count", 32'(a_count), 32'(i % 64));
      checkOutput("sweep A ovf_p", 32'(a_ovf_p), 32'(i == 64));
      if (i == 63) checkOutput("sweep A at_max", 32'(a_at_max), 1);
    end
    checkOutput("sweep A ovf_sticky", 32'(a_ovf_sticky), 1);

    // Down wrap with a large step
    applyStimulus(0, 0, 1, 6'd2, 0, 0, 0, 6'd5, 0);
    checkA("load2", 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 6'd5, 0);
    checkA("dnwrap1", 61, 0, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 6'd5, 0);
    checkA("dnwrap2", 56, 0, 0);
    checkOutput("dnwrap A udf_sticky", 32'(a_udf_sticky), 1);

    // Reset in the middle of counting clears count and all flags
    applyStimulus(0, 0, 1, 6'd39, 0, 1, 0, 6'd1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 6'd1, 0);
    checkA("pre-reset", 40, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 6'd1, 0);
    checkA("midreset", 0, 0, 0);
    checkOutput("midreset A ovf_sticky", 32'(a_ovf_sticky), 0);
    checkOutput("midreset A udf_sticky", 32'(a_udf_sticky), 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 6'd1, 0);
    checkA("post-reset", 1, 0, 0);

    // Load wins over enable; zero step holds without pulses
    applyStimulus(0, 0, 1, 6'd10, 1, 1, 0, 6'd1, 0);
    checkA("load+en", 10, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 6'd0, 0);
    checkA("step0", 10, 0, 0);

    // A new overflow on the same edge as flag_clr keeps the sticky set
    applyStimulus(0, 0, 1, 6'd63, 0, 1, 0, 6'd1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 6'd1, 1);
    checkA("clr+ovf", 0, 1, 0);
    checkOutput("clr+ovf A ovf_sticky", 32'(a_ovf_sticky), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 6'd1, 1);
    checkA("clr", 0, 0, 0);
    checkOutput("clr A ovf_sticky", 32'(a_ovf_sticky), 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 6'd1, 0);
    checkA("dn 0->63", 63, 0, 1);

    // Saturation on the MAX_VAL=9 build
    applyStimulus(1, 0, 1, 6'd7, 0, 1, 1, 6'd4, 0);
    checkB("load7", 7, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 1, 6'd4, 0);
    checkB("sat1", 9, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 1, 1, 6'd4, 0);
    checkB("sat2", 9, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 6'd4, 0);
    checkB("sat down", 5, 0, 0);
    checkOutput("sat B ovf_sticky", 32'(b_ovf_sticky), 1);

    // Clamping of load value and step
    applyStimulus(1, 0, 1, 6'd15, 0, 1, 0, 6'd1, 0);
    checkB("clamp load", 9, 0, 0);
    checkOutput("clamp B at_max", 32'(b_at_max), 1);
    applyStimulus(1, 0, 1, 6'd0, 0, 1, 0, 6'd12, 0);
    checkOutput("load0 B at_zero", 32'(b_at_zero), 1);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 6'd12, 0);
    checkB("clamp step", 9, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 6'd12, 0);
    checkB("dn to 0 exact", 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1, 6'd3, 0);
    checkB("dn sat", 0, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 0, 0, 6'd3, 0);
    checkB("dn wrap", 7, 0, 1);
    applyStimulus(1, 0, 0, 0, 1, 1, 0, 6'd5, 0);
    checkB("up wrap", 2, 1, 0);
    checkOutput("B udf_sticky", 32'(b_udf_sticky), 1);

    // Reset beats load on the non-zero reset build
    applyStimulus(1, 1, 1, 6'd5, 1, 1, 0, 6'd1, 0);
    checkB("reset>load", 2, 0, 0);
    checkOutput("reset B ovf_sticky", 32'(b_ovf_sticky), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
